// File: rtl/fwd_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fwd_hazard_unit_pkg
// Brief   : Shared register-address width, fwd_sel encoding and FSM state type.
// Revision: 1.0 - initial release
// ============================================================================
`ifndef REG_ADDRESS_LENGTH
`define REG_ADDRESS_LENGTH 5
`endif

package fwd_hazard_unit_pkg;

    localparam int unsigned FWD_SEL_W     = 3;
    localparam logic [2:0]  FWD_RF        = 3'd0;
    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } hazState_t;

    // Forwarding stage k is reported as k+1 so that 0 can mean "register file".
    function automatic logic [FWD_SEL_W-1:0] stgSel(input int unsigned k);
        return FWD_SEL_W'(k + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_hazard_unit_fwd_match.sv
`default_nettype none
// ============================================================================
// Module  : fwd_match
// Brief   : Priority match of one source address against all forwarding stages.
// Revision: 1.0 - initial release
// ============================================================================
module fwd_match
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = `REG_ADDRESS_LENGTH,
    parameter int unsigned NUM_STG    = 2
) (
    input  logic [REG_ADDR_W-1:0]         src,
    input  logic [NUM_STG*REG_ADDR_W-1:0] stg_rd,
    input  logic [NUM_STG-1:0]            stg_regwrite,
    output logic [FWD_SEL_W-1:0]          sel
);

    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
        sel = FWD_RF;
        for (int k = NUM_STG - 1; k >= 0; k--) begin
            if (stg_regwrite[k]
                && (stg_rd[k*REG_ADDR_W +: REG_ADDR_W] != '0)
                && (stg_rd[k*REG_ADDR_W +: REG_ADDR_W] == src)) begin
                sel = stgSel(k);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module  : fwd_hazard_unit
// Brief   : Operand forwarding select plus load-use stall/bubble control.
// Revision: 1.0 - initial release
// ============================================================================
`ifndef REG_ADDRESS_LENGTH
`define REG_ADDRESS_LENGTH 5
`endif

module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = `REG_ADDRESS_LENGTH,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned NUM_STG    = 2,
    parameter int unsigned LOAD_LAT   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_src,
    input  logic [NUM_STG*REG_ADDR_W-1:0] stg_rd,
    input  logic [NUM_STG-1:0]            stg_regwrite,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic                          id_valid,
    input  logic                          ex_is_load,
    input  logic [REG_ADDR_W-1:0]         ex_rd,
    input  logic                          mem_wait,
    input  logic                          flush,
    output logic [NUM_SRC*3-1:0]          fwd_sel,
    output logic                          stall,
    output logic                          bubble,
    output logic [15:0]                   stall_count
);

    localparam logic [2:0] c_loadCnt = 3'(LOAD_LAT - 1);

    hazState_t   r_state;
    logic [2:0]  r_cnt;
    logic [15:0] r_stallCount;
    logic        w_hazard;
    logic        w_stallReq;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            fwd_match #(
                .REG_ADDR_W (REG_ADDR_W),
                .NUM_STG    (NUM_STG)
            ) u_fwdMatch (
                .src          (ex_src[i*REG_ADDR_W +: REG_ADDR_W]),
                .stg_rd       (stg_rd),
                .stg_regwrite (stg_regwrite),
                .sel          (fwd_sel[i*3 +: 3])
            );
        end
    endgenerate

    always_comb begin
        w_hazard = 1'b0;
        if (id_valid && ex_is_load && (ex_rd != '0)) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (id_src_used[i] && (id_src[i*REG_ADDR_W +: REG_ADDR_W] == ex_rd)) begin
                    w_hazard = 1'b1;
                end
            end
        end
    end

    // Stall is asserted in the detecting cycle itself; flush overrides everything.
    assign w_stallReq  = !flush && ((r_state == ST_STALL) || w_hazard);
    assign stall       = w_stallReq;
    assign bubble      = w_stallReq;
    assign stall_count = r_stallCount;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 3'd0;
            r_stallCount <= 16'd0;
        end else begin
            if (w_stallReq && (r_stallCount != STALL_CNT_MAX)) begin
                r_stallCount <= r_stallCount + 16'd1;
            end
            if (flush) begin
                r_state <= ST_IDLE;
                r_cnt   <= 3'd0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_hazard) begin
                            r_state <= (LOAD_LAT > 1) ? ST_STALL : ST_IDLE;
                            r_cnt   <= c_loadCnt;
                        end
                    end
                    ST_STALL: begin
                        // A slow data memory freezes the countdown.
                        if (!mem_wait) begin
                            if (r_cnt == 3'd1) begin
                                r_state <= ST_IDLE;
                                r_cnt   <= 3'd0;
                            end else begin
                                r_cnt <= r_cnt - 3'd1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 3'd0;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_fwd_hazard_unit
// Brief   : Self-checking bench for fwd_hazard_unit (LOAD_LAT 1 and 3 instances).
// Revision: 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

    localparam int W  = 5;
    localparam int NS = 2;
    localparam int NG = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS*W-1:0] ex_src, id_src;
    logic [NG*W-1:0] stg_rd;
    logic [NG-1:0]   stg_regwrite;
    logic [NS-1:0]   id_src_used;
    logic            id_valid, ex_is_load, mem_wait, flush;
    logic [W-1:0]    ex_rd;

    logic [NS*3-1:0] fwdSel1, fwdSel3;
    logic            stall1, bubble1, stall3, bubble3;
    logic [15:0]     cnt1, cnt3;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_ADDR_W(W), .NUM_SRC(NS), .NUM_STG(NG), .LOAD_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .ex_src(ex_src), .stg_rd(stg_rd), .stg_regwrite(stg_regwrite),
        .id_src(id_src), .id_src_used(id_src_used), .id_valid(id_valid), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .mem_wait(mem_wait), .flush(flush), .fwd_sel(fwdSel1),
        .stall(stall1), .bubble(bubble1), .stall_count(cnt1)
    );

    fwd_hazard_unit #(.REG_ADDR_W(W), .NUM_SRC(NS), .NUM_STG(NG), .LOAD_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .ex_src(ex_src), .stg_rd(stg_rd), .stg_regwrite(stg_regwrite),
        .id_src(id_src), .id_src_used(id_src_used), .id_valid(id_valid), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .mem_wait(mem_wait), .flush(flush), .fwd_sel(fwdSel3),
        .stall(stall3), .bubble(bubble3), .stall_count(cnt3)
    );

    int   nCompared   = 0;
    int   nMismatched = 0;
    int   lat [2]     = '{1, 3};
    int   remain [2];
    int   refCount [2];
    logic obsStall [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: youngest stage whose write targets this nonzero source register.
    function automatic int refFwd(input int i);
        for (int k = 0; k < NG; k++) begin
            if (stg_regwrite[k] && stg_rd[k*W +: W] != 0 && stg_rd[k*W +: W] == ex_src[i*W +: W])
                return k + 1;
        end
        return 0;
    endfunction

    function automatic bit refHazard();
        if (!id_valid || !ex_is_load || ex_rd == 0) return 1'b0;
        for (int i = 0; i < NS; i++)
            if (id_src_used[i] && id_src[i*W +: W] == ex_rd) return 1'b1;
        return 1'b0;
    endfunction

    // remain = stall cycles still owed after the current one.
    function automatic bit refStall(input int u);
        if (flush) return 1'b0;
        if (remain[u] > 0) return 1'b1;
        return refHazard();
    endfunction

    task automatic checkAll();
        for (int i = 0; i < NS; i++) begin
            chk("fwd_sel_lat1", 32'(fwdSel1[i*3 +: 3]), refFwd(i));
            chk("fwd_sel_lat3", 32'(fwdSel3[i*3 +: 3]), refFwd(i));
        end
        chk("stall_lat1",  32'(stall1),  32'(refStall(0)));
        chk("bubble_lat1", 32'(bubble1), 32'(refStall(0)));
        chk("stall_lat3",  32'(stall3),  32'(refStall(1)));
        chk("bubble_lat3", 32'(bubble3), 32'(refStall(1)));
        chk("count_lat1",  32'(cnt1),    refCount[0]);
        chk("count_lat3",  32'(cnt3),    refCount[1]);
        obsStall[0] = stall1;
        obsStall[1] = stall3;
    endtask

    task automatic modelTick();
        bit s [2];
        bit h;
        h = refHazard();
        for (int u = 0; u < 2; u++) s[u] = refStall(u);
        for (int u = 0; u < 2; u++) begin
            if (s[u] && refCount[u] < 65535) refCount[u]++;
            if (flush) remain[u] = 0;
            else if (remain[u] > 0) begin
                if (!mem_wait) remain[u]--;
            end else if (h) remain[u] = lat[u] - 1;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        checkAll();
        @(posedge clk);
        modelTick();
        #1;
    endtask

    task automatic modelReset();
        for (int u = 0; u < 2; u++) begin
            remain[u]   = 0;
            refCount[u] = 0;
        end
    endtask

    task automatic clearInputs();
        ex_src = '0; id_src = '0; stg_rd = '0; stg_regwrite = '0; id_src_used = '0;
        id_valid = 1'b0; ex_is_load = 1'b0; mem_wait = 1'b0; flush = 1'b0; ex_rd = '0;
    endtask

    task automatic setHazard();
        id_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd7;
        id_src = {5'd7, 5'd0}; id_src_used = 2'b10;
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count_lat3", 32'(cnt3), 0);
        chk("reset_stall_lat3", 32'(stall3), 0);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b0;
        clearInputs();
        #1;
        doReset();

        // Forwarding priority with both stages targeting r3.
        ex_src = {5'd0, 5'd3}; stg_rd = {5'd3, 5'd3}; stg_regwrite = 2'b11;
        #1 chk("fwd_mem_wins", 32'(fwdSel1[2:0]), 1);
        stg_regwrite = 2'b10;
        #1 chk("fwd_wb_only", 32'(fwdSel1[2:0]), 2);
        stg_rd = '0; stg_regwrite = 2'b11;
        #1 chk("fwd_r0_never", 32'(fwdSel1[2:0]), 0);
        cyc();

        // Single-cycle load-use stall.
        doReset();
        setHazard();
        cyc();
        chk("lat1_stall_c1", 32'(obsStall[0]), 1);
        id_src_used = 2'b00;
        cyc();
        chk("lat1_unused_nostall", 32'(obsStall[0]), 0);
        chk("lat1_count", 32'(cnt1), 1);

        // Three-cycle stall stretched by two mem_wait cycles.
        doReset();
        setHazard();
        cyc();
        n = int'(obsStall[1]);
        clearInputs();
        mem_wait = 1'b1;
        repeat (2) begin cyc(); n += int'(obsStall[1]); end
        mem_wait = 1'b0;
        repeat (3) begin cyc(); n += int'(obsStall[1]); end
        chk("lat3_memwait_len", n, 5);
        chk("lat3_memwait_count", 32'(cnt3), 5);

        // Flush on the second stall cycle.
        doReset();
        setHazard();
        cyc();
        clearInputs();
        flush = 1'b1;
        cyc();
        chk("flush_kills_stall", 32'(obsStall[1]), 0);
        flush = 1'b0;
        cyc();
        chk("flush_then_idle", 32'(obsStall[1]), 0);
        chk("flush_count", 32'(cnt3), 1);

        // Asynchronous reset in the middle of a stall.
        doReset();
        setHazard();
        cyc();
        clearInputs();
        cyc();
        #2 rst = 1'b1;
        modelReset();
        #1;
        chk("async_rst_count", 32'(cnt3), 0);
        chk("async_rst_stall", 32'(stall3), 0);
        #1 rst = 1'b0;
        cyc();

        // Randomized traffic against the reference model.
        repeat (400) begin
            for (int i = 0; i < NS; i++) begin
                ex_src[i*W +: W] = 5'($urandom_range(0, 7));
                id_src[i*W +: W] = 5'($urandom_range(0, 7));
            end
            for (int k = 0; k < NG; k++) stg_rd[k*W +: W] = 5'($urandom_range(0, 7));
            stg_regwrite = NG'($urandom);
            id_src_used  = NS'($urandom);
            id_valid     = ($urandom_range(0, 3) != 0);
            ex_is_load   = $urandom_range(0, 1) != 0;
            ex_rd        = 5'($urandom_range(0, 7));
            mem_wait     = ($urandom_range(0, 2) == 0);
            flush        = ($urandom_range(0, 9) == 0);
            cyc();
        end

        // Continuous stalling until the counter saturates.
        doReset();
        setHazard();
        for (int c = 0; c < 65540; c++) cyc();
        chk("sat_hold_lat1", 32'(cnt1), 32'hFFFF);
        chk("sat_hold_lat3", 32'(cnt3), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

`default_nettype wire
